branch_exec_unit: RTL and testbench

//  Consumes B-type decoder fields (op, funct3, 20-bit imm) plus operand values and the instruction PC;

---
 rtl/rv32i_pkg.sv | 18 +
 rtl/branch_exec_unit_if.sv | 36 +++
 rtl/branch_cmp.sv | 32 +++
 rtl/branch_exec_unit.sv | 133 +++++++++++++
 tb/tb_branch_exec_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I branch decode constants and the B-type immediate sign-extension helper.
package rv32i_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Decoder packs imm12..imm1 into bits [11:0]; bit 0 of the byte offset is implicit zero.
    function automatic logic [31:0] b_imm_sext(input logic [11:0] imm);
        return {{19{imm[11]}}, imm, 1'b0};
    endfunction

endpackage

// File: rtl/branch_exec_unit_if.sv
// Upstream (decode/regread) and downstream (redirect/commit) handshake bundle for the branch unit.
interface branch_exec_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) ();
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [6:0]       in_op;
    logic [2:0]       in_funct3;
    logic [19:0]      in_imm;
    logic [XLEN-1:0]  in_rs1_val;
    logic [XLEN-1:0]  in_rs2_val;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic [XLEN-1:0]  out_target;
    logic [XLEN-1:0]  out_next_pc;
    logic             out_illegal;
    logic             out_misaligned;
    logic [CNT_W-1:0] cnt_branches;
    logic [CNT_W-1:0] cnt_taken;

    modport slave (
        input  flush, in_valid, in_pc, in_op, in_funct3, in_imm, in_rs1_val, in_rs2_val, out_ready,
        output in_ready, out_valid, out_taken, out_target, out_next_pc, out_illegal, out_misaligned,
               cnt_branches, cnt_taken
    );

    modport master (
        output flush, in_valid, in_pc, in_op, in_funct3, in_imm, in_rs1_val, in_rs2_val, out_ready,
        input  in_ready, out_valid, out_taken, out_target, out_next_pc, out_illegal, out_misaligned,
               cnt_branches, cnt_taken
    );
endinterface

// File: rtl/branch_cmp.sv
// Combinational funct3 comparator: resolves the branch condition and flags reserved funct3 codes.
module branch_cmp
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_taken,
    output logic            o_illegal_f3
);
    logic signed [XLEN-1:0] w_rs1_s;
    logic signed [XLEN-1:0] w_rs2_s;

    assign w_rs1_s = i_rs1;
    assign w_rs2_s = i_rs2;

    always_comb begin
        o_taken      = 1'b0;
        o_illegal_f3 = 1'b0;
        unique case (i_funct3)
            F3_BEQ:  o_taken = (i_rs1 == i_rs2);
            F3_BNE:  o_taken = (i_rs1 != i_rs2);
            F3_BLT:  o_taken = (w_rs1_s <  w_rs2_s);
            F3_BGE:  o_taken = (w_rs1_s >= w_rs2_s);
            F3_BLTU: o_taken = (i_rs1 <  i_rs2);
            F3_BGEU: o_taken = (i_rs1 >= i_rs2);
            default: o_illegal_f3 = 1'b1;
        endcase
    end
endmodule

// File: rtl/branch_exec_unit.sv
// Two-stage branch resolution pipeline: operand capture, then compare/target/flags, with
// valid/ready backpressure, flush, and saturating retire statistics.
module branch_exec_unit
    import rv32i_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int XLEN  = 32
) (
    input logic                clk,
    input logic                rst,
    branch_exec_unit_if.slave  bus
);
    logic             r_vld_p1;
    logic [XLEN-1:0]  r_pc_p1;
    logic [6:0]       r_op_p1;
    logic [2:0]       r_f3_p1;
    logic [XLEN-1:0]  r_off_p1;
    logic [XLEN-1:0]  r_rs1_p1;
    logic [XLEN-1:0]  r_rs2_p1;

    logic             r_vld_p2;
    logic             r_taken_p2;
    logic [XLEN-1:0]  r_target_p2;
    logic [XLEN-1:0]  r_next_pc_p2;
    logic             r_illegal_p2;
    logic             r_misaligned_p2;

    logic [CNT_W-1:0] r_cnt_branches;
    logic [CNT_W-1:0] r_cnt_taken;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_retire;
    logic             w_cmp_taken;
    logic             w_illegal_f3;
    logic             w_illegal;
    logic             w_taken;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_pc_plus4;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_s2_adv   = !r_vld_p2 || bus.out_ready;
    assign w_s1_adv   = r_vld_p1 && w_s2_adv;
    // Flush blocks capture so nothing new enters while in-flight entries are being killed.
    assign w_in_ready = (!r_vld_p1 || w_s2_adv) && !bus.flush;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_retire   = r_vld_p2 && bus.out_ready && !r_illegal_p2;

    // ---- stage 1: operand capture ----
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_vld_p1 <= 1'b0;
        end else if (w_accept) begin
            r_vld_p1 <= 1'b1;
        end else if (w_s1_adv) begin
            r_vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pc_p1  <= bus.in_pc;
            r_op_p1  <= bus.in_op;
            r_f3_p1  <= bus.in_funct3;
            r_off_p1 <= b_imm_sext(bus.in_imm[11:0]);
            r_rs1_p1 <= bus.in_rs1_val;
            r_rs2_p1 <= bus.in_rs2_val;
        end
    end

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .i_funct3     (r_f3_p1),
        .i_rs1        (r_rs1_p1),
        .i_rs2        (r_rs2_p1),
        .o_taken      (w_cmp_taken),
        .o_illegal_f3 (w_illegal_f3)
    );

    assign w_illegal  = (r_op_p1 != OP_BRANCH) || w_illegal_f3;
    assign w_taken    = w_cmp_taken && !w_illegal;
    assign w_target   = r_pc_p1 + r_off_p1;
    assign w_pc_plus4 = r_pc_p1 + XLEN'(4);

    // ---- stage 2: resolved result ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2        <= 1'b0;
            r_taken_p2      <= 1'b0;
            r_target_p2     <= '0;
            r_next_pc_p2    <= '0;
            r_illegal_p2    <= 1'b0;
            r_misaligned_p2 <= 1'b0;
        end else if (bus.flush) begin
            r_vld_p2 <= 1'b0;
        end else if (w_s2_adv) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_taken_p2      <= w_taken;
                r_target_p2     <= w_target;
                r_next_pc_p2    <= w_taken ? w_target : w_pc_plus4;
                r_illegal_p2    <= w_illegal;
                r_misaligned_p2 <= w_taken && (w_target[1:0] != 2'b00);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_branches <= '0;
            r_cnt_taken    <= '0;
        end else if (w_retire) begin
            r_cnt_branches <= sat_inc(r_cnt_branches);
            if (r_taken_p2) begin
                r_cnt_taken <= sat_inc(r_cnt_taken);
            end
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = r_vld_p2;
    assign bus.out_taken      = r_taken_p2;
    assign bus.out_target     = r_target_p2;
    assign bus.out_next_pc    = r_next_pc_p2;
    assign bus.out_illegal    = r_illegal_p2;
    assign bus.out_misaligned = r_misaligned_p2;
    assign bus.cnt_branches   = r_cnt_branches;
    assign bus.cnt_taken      = r_cnt_taken;
endmodule

// File: tb/tb_branch_exec_unit.sv
// Directed vector bench for branch_exec_unit: table of single branches plus stall/flush/saturate/reset sequences.
module tb_branch_exec_unit;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam logic [6:0] OPB = 7'b1100011;

    logic clk;
    logic rst;

    branch_exec_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    branch_exec_unit #(.CNT_W(CNT_W), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [19:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        taken;
        logic [31:0] target;
        logic [31:0] next_pc;
        logic        illegal;
        logic        mis;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;
    int m_br   = 0;
    int m_tk   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_retire(input logic taken, input logic illegal);
        if (!illegal) begin
            if (m_br < 15) m_br++;
            if (taken && m_tk < 15) m_tk++;
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [6:0] op, input logic [2:0] f3,
                         input logic [19:0] imm, input logic [31:0] rs1, input logic [31:0] rs2);
        bus.in_pc      = pc;
        bus.in_op      = op;
        bus.in_funct3  = f3;
        bus.in_imm     = imm;
        bus.in_rs1_val = rs1;
        bus.in_rs2_val = rs2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[14];
    logic [31:0] seq_pc[3];
    logic [31:0] seq_tgt[3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, got, ret, seen;
        logic a, r;

        vecs[0]  = '{32'h100, OPB, 3'b000, 20'h00004, 32'd5, 32'd5, 1, 32'h108, 32'h108, 0, 0};
        vecs[1]  = '{32'h100, OPB, 3'b100, 20'h00004, 32'hFFFFFFFF, 32'd1, 1, 32'h108, 32'h108, 0, 0};
        vecs[2]  = '{32'h100, OPB, 3'b110, 20'h00004, 32'hFFFFFFFF, 32'd1, 0, 32'h108, 32'h104, 0, 0};
        vecs[3]  = '{32'h200, OPB, 3'b001, 20'h00FFE, 32'd1, 32'd2, 1, 32'h1FC, 32'h1FC, 0, 0};
        vecs[4]  = '{32'hFFFFFFFC, OPB, 3'b001, 20'h00004, 32'd1, 32'd2, 1, 32'h4, 32'h4, 0, 0};
        vecs[5]  = '{32'h100, OPB, 3'b000, 20'h00001, 32'd9, 32'd9, 1, 32'h102, 32'h102, 0, 1};
        vecs[6]  = '{32'h100, OPB, 3'b010, 20'h00004, 32'd5, 32'd5, 0, 32'h108, 32'h104, 1, 0};
        vecs[7]  = '{32'h100, OPB, 3'b101, 20'h00004, 32'hFFFFFFFF, 32'd1, 0, 32'h108, 32'h104, 0, 0};
        vecs[8]  = '{32'h100, OPB, 3'b111, 20'h00004, 32'hFFFFFFFF, 32'd1, 1, 32'h108, 32'h108, 0, 0};
        vecs[9]  = '{32'h100, 7'h13, 3'b000, 20'h00004, 32'd5, 32'd5, 0, 32'h108, 32'h104, 1, 0};
        vecs[10] = '{32'h100, OPB, 3'b000, 20'h00004, 32'd5, 32'd6, 0, 32'h108, 32'h104, 0, 0};
        vecs[11] = '{32'h100, OPB, 3'b000, 20'hAB004, 32'd3, 32'd3, 1, 32'h108, 32'h108, 0, 0};
        vecs[12] = '{32'h300, OPB, 3'b101, 20'h00010, 32'd7, 32'd7, 1, 32'h320, 32'h320, 0, 0};
        vecs[13] = '{32'h100, OPB, 3'b011, 20'h00004, 32'd1, 32'd2, 0, 32'h108, 32'h104, 1, 0};

        rst = 1'b1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive(32'h0, 7'h0, 3'h0, 20'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("reset_in_ready", {31'b0, bus.in_ready}, 32'h1);
        chk("reset_out_target", bus.out_target, 32'h0);
        chk("reset_out_next_pc", bus.out_next_pc, 32'h0);
        chk("reset_cnt_branches", 32'(bus.cnt_branches), 32'h0);
        chk("reset_cnt_taken", 32'(bus.cnt_taken), 32'h0);

        // Table: one branch at a time, fixed two-cycle latency, retired the following edge.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].pc, vecs[i].op, vecs[i].f3, vecs[i].imm, vecs[i].rs1, vecs[i].rs2);
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            chk($sformatf("v%0d_not_early", i), {31'b0, bus.out_valid}, 32'h0);
            tick();
            chk($sformatf("v%0d_out_valid", i), {31'b0, bus.out_valid}, 32'h1);
            chk($sformatf("v%0d_taken", i), {31'b0, bus.out_taken}, {31'b0, vecs[i].taken});
            chk($sformatf("v%0d_target", i), bus.out_target, vecs[i].target);
            chk($sformatf("v%0d_next_pc", i), bus.out_next_pc, vecs[i].next_pc);
            chk($sformatf("v%0d_illegal", i), {31'b0, bus.out_illegal}, {31'b0, vecs[i].illegal});
            chk($sformatf("v%0d_misaligned", i), {31'b0, bus.out_misaligned}, {31'b0, vecs[i].mis});
            model_retire(vecs[i].taken, vecs[i].illegal);
            tick();
            chk($sformatf("v%0d_cnt_branches", i), 32'(bus.cnt_branches), 32'(m_br));
            chk($sformatf("v%0d_cnt_taken", i), 32'(bus.cnt_taken), 32'(m_tk));
        end

        // Backpressure: three entries offered while the output is stalled.
        seq_pc[0] = 32'h1000; seq_pc[1] = 32'h2000; seq_pc[2] = 32'h3000;
        seq_tgt[0] = 32'h1008; seq_tgt[1] = 32'h2008; seq_tgt[2] = 32'h3008;
        bus.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            bus.in_valid = (acc < 3);
            drive(seq_pc[acc < 3 ? acc : 2], OPB, 3'b000, 20'h00004, 32'd1, 32'd1);
            #1;
            a = bus.in_valid && bus.in_ready;
            tick();
            if (a) acc++;
        end
        chk("stall_accepted", 32'(acc), 32'd2);
        chk("stall_in_ready", {31'b0, bus.in_ready}, 32'h0);
        chk("stall_out_valid", {31'b0, bus.out_valid}, 32'h1);
        chk("stall_held_target", bus.out_target, 32'h1008);
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            bus.in_valid = (acc < 3);
            drive(seq_pc[acc < 3 ? acc : 2], OPB, 3'b000, 20'h00004, 32'd1, 32'd1);
            #1;
            a = bus.in_valid && bus.in_ready;
            r = bus.out_valid && bus.out_ready;
            if (r) begin
                chk($sformatf("order_%0d_target", got), bus.out_target, seq_tgt[got]);
                model_retire(1'b1, 1'b0);
                got++;
            end
            tick();
            if (a) acc++;
        end
        bus.in_valid = 1'b0;
        chk("release_results", 32'(got), 32'd3);
        chk("release_accepted", 32'(acc), 32'd3);
        tick();
        chk("release_drained", {31'b0, bus.out_valid}, 32'h0);
        chk("release_cnt_branches", 32'(bus.cnt_branches), 32'(m_br));

        // Flush with both stages full; the entry offered during flush must not be captured.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        drive(32'h500, OPB, 3'b000, 20'h00004, 32'd1, 32'd1);
        tick();
        drive(32'h600, OPB, 3'b000, 20'h00004, 32'd1, 32'd1);
        tick();
        chk("preflush_out_valid", {31'b0, bus.out_valid}, 32'h1);
        drive(32'h700, OPB, 3'b000, 20'h00004, 32'd1, 32'd1);
        bus.flush = 1'b1;
        #1;
        chk("flush_in_ready", {31'b0, bus.in_ready}, 32'h0);
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", {31'b0, bus.out_valid}, 32'h0);
        bus.out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        chk("flush_no_leftover", 32'(seen), 32'd0);
        chk("flush_cnt_branches", 32'(bus.cnt_branches), 32'(m_br));
        chk("flush_cnt_taken", 32'(bus.cnt_taken), 32'(m_tk));

        // Saturation: 20 back-to-back taken branches on a 4-bit counter.
        acc = 0;
        ret = 0;
        for (int c = 0; c < 80 && ret < 20; c++) begin
            bus.in_valid = (acc < 20);
            drive(32'h400 + 32'(acc) * 4, OPB, 3'b000, 20'h00004, 32'd2, 32'd2);
            #1;
            a = bus.in_valid && bus.in_ready;
            r = bus.out_valid && bus.out_ready;
            tick();
            if (a) acc++;
            if (r) begin
                ret++;
                model_retire(1'b1, 1'b0);
            end
        end
        bus.in_valid = 1'b0;
        chk("sat_retired", 32'(ret), 32'd20);
        chk("sat_cnt_taken", 32'(bus.cnt_taken), 32'(m_tk));
        chk("sat_cnt_taken_15", 32'(bus.cnt_taken), 32'd15);
        chk("sat_cnt_branches_15", 32'(bus.cnt_branches), 32'd15);

        // Reset mid-stream with both stages occupied.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        drive(32'h800, OPB, 3'b000, 20'h00004, 32'd1, 32'd1);
        tick();
        tick();
        chk("prerst_out_valid", {31'b0, bus.out_valid}, 32'h1);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'h1);
        chk("midrst_out_target", bus.out_target, 32'h0);
        chk("midrst_cnt_branches", 32'(bus.cnt_branches), 32'h0);
        chk("midrst_cnt_taken", 32'(bus.cnt_taken), 32'h0);
        bus.out_ready = 1'b1;
        tick();
        chk("midrst_no_ghost", {31'b0, bus.out_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
